// File: rtl/mpack_pkg.sv
// mpack_pkg: shared definitions for the pico-pack memory bus.
//   fwd (69b) = {wdata[68:37], wstrb[36:33], valid[32], addr[31:0]}
//   ret (33b) = {ready[32], rdata[31:0]}
// Also holds the arbiter state type and a response-packing helper.
package mpack_pkg;

    localparam int FWD_W     = 69;
    localparam int RET_W     = 33;
    localparam int ADDR_LSB  = 0;
    localparam int VALID_BIT = 32;
    localparam int WSTRB_LSB = 33;
    localparam int WDATA_LSB = 37;
    localparam int READY_BIT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    function automatic logic [RET_W-1:0] mk_ret(input logic ready, input logic [31:0] rdata);
        logic [RET_W-1:0] r;
        r            = '0;
        r[READY_BIT] = ready;
        r[31:0]      = rdata;
        return r;
    endfunction

endpackage

// File: rtl/mpack_arbiter2_if.sv
// mpack_arbiter2_if: bundle of the two-master / one-slave bus signals.
//   m0_fwd/m1_fwd : master requests          m0_ret/m1_ret : master responses
//   s_fwd         : request to shared slave  s_ret         : slave response
//   grant         : one-hot owner (00 idle)  timeout_err   : sticky watchdog flag
//   err_clr       : clears timeout_err
// Modport slave is the arbiter's view; master is the surrounding system's view.
interface mpack_arbiter2_if;
    import mpack_pkg::*;

    logic [FWD_W-1:0] m0_fwd;
    logic [FWD_W-1:0] m1_fwd;
    logic [FWD_W-1:0] s_fwd;
    logic [RET_W-1:0] m0_ret;
    logic [RET_W-1:0] m1_ret;
    logic [RET_W-1:0] s_ret;
    logic [1:0]       grant;
    logic             timeout_err;
    logic             err_clr;

    modport slave (
        input  m0_fwd, m1_fwd, s_ret, err_clr,
        output m0_ret, m1_ret, s_fwd, grant, timeout_err
    );

    modport master (
        output m0_fwd, m1_fwd, s_ret, err_clr,
        input  m0_ret, m1_ret, s_fwd, grant, timeout_err
    );

endinterface

// File: rtl/mpack_rr_pick.sv
// mpack_rr_pick: combinational two-way round-robin pick.
//   req_i[1:0]   : {req1, req0}
//   last_owner_i : 0 = master 0 served last, 1 = master 1 served last
//   pick_o[1:0]  : one-hot winner, 00 when nobody requests
module mpack_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o = '0;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            // On a tie the master that did not own the bus last wins.
            2'b11:   pick_o = last_owner_i ? 2'b01 : 2'b10;
            default: pick_o = '0;
        endcase
    end

endmodule

// File: rtl/mpack_arbiter2.sv
// mpack_arbiter2: round-robin arbiter letting two pico-pack masters share one
// slave segment. Each access is held until the slave returns ready; a watchdog
// forces completion (rdata = TO_RDATA) after TIMEOUT_CYCLES unanswered cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mpack_arbiter2_if.slave (m0/m1 fwd+ret, s_fwd/s_ret, grant,
//              timeout_err, err_clr)
module mpack_arbiter2
    import mpack_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8,
    parameter logic [31:0] TO_RDATA       = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    mpack_arbiter2_if.slave     bus
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;     // 1 = master 1 owned the bus last
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [1:0]       pick;
    logic             s_ready;
    logic [FWD_W-1:0] owner_fwd;

    assign s_ready   = bus.s_ret[READY_BIT];
    assign owner_fwd = grant_q[1] ? bus.m1_fwd : bus.m0_fwd;

    mpack_rr_pick u_pick (
        .req_i        ({bus.m1_fwd[VALID_BIT], bus.m0_fwd[VALID_BIT]}),
        .last_owner_i (last_q),
        .pick_o       (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        // The DONE branch below overrides this, so a forced completion wins
        // over a simultaneous clear.
        err_d   = bus.err_clr ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    state_d = GRANT;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (s_ready) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = grant_q[1];
                end else if (cnt_q == TO_LIM) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = grant_q[1];
                err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.s_fwd  = '0;
        bus.m0_ret = '0;
        bus.m1_ret = '0;
        case (state_q)
            GRANT: begin
                bus.s_fwd = {owner_fwd[WDATA_LSB +: 32], owner_fwd[WSTRB_LSB +: 4],
                             owner_fwd[VALID_BIT], owner_fwd[ADDR_LSB +: 32]};
                if (grant_q[1]) bus.m1_ret = bus.s_ret;
                else            bus.m0_ret = bus.s_ret;
            end
            DONE: begin
                if (grant_q[1]) bus.m1_ret = mk_ret(1'b1, TO_RDATA);
                else            bus.m0_ret = mk_ret(1'b1, TO_RDATA);
            end
            default: ;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_mpack_arbiter2.sv
module tb_mpack_arbiter2;

    localparam int          TO  = 4;
    localparam logic [31:0] TOD = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpack_arbiter2_if bus();

    mpack_arbiter2 #(.TIMEOUT_CYCLES(TO), .CNT_W(8), .TO_RDATA(TOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who holds an open access, how long it has waited,
    // whether it is in its forced-completion cycle, who was served last.
    int mown  = -1;
    int mage  = 0;
    int mlast = 1;
    bit mexp  = 1'b0;
    bit merr  = 1'b0;

    typedef struct {
        logic [68:0] m0;
        logic [68:0] m1;
        logic [32:0] sr;
        logic [1:0]  g;
        logic [32:0] r0;
        logic [32:0] r1;
        logic [68:0] sf;
    } vec_t;

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic [1:0]  eg;
        logic [68:0] esf;
        logic [32:0] er0, er1;
        eg  = (mown < 0) ? 2'b00 : ((mown == 0) ? 2'b01 : 2'b10);
        esf = '0;
        er0 = '0;
        er1 = '0;
        if (mown >= 0) begin
            if (mexp) begin
                if (mown == 0) er0 = {1'b1, TOD};
                else           er1 = {1'b1, TOD};
            end else begin
                esf = (mown == 0) ? bus.m0_fwd : bus.m1_fwd;
                if (mown == 0) er0 = bus.s_ret;
                else           er1 = bus.s_ret;
            end
        end
        chk("grant",       69'(bus.grant),       69'(eg));
        chk("s_fwd",       bus.s_fwd,            esf);
        chk("m0_ret",      69'(bus.m0_ret),      69'(er0));
        chk("m1_ret",      69'(bus.m1_ret),      69'(er1));
        chk("timeout_err", 69'(bus.timeout_err), 69'(merr));
    endtask

    task automatic step_model();
        bit v0, v1;
        v0 = bus.m0_fwd[32];
        v1 = bus.m1_fwd[32];
        if (rst) begin
            mown = -1; mage = 0; mlast = 1; mexp = 1'b0; merr = 1'b0;
        end else begin
            if (bus.err_clr) merr = 1'b0;
            if (mown < 0) begin
                if (v0 && v1)  mown = 1 - mlast;
                else if (v0)   mown = 0;
                else if (v1)   mown = 1;
                mage = 0;
            end else if (mexp) begin
                mlast = mown; mown = -1; mexp = 1'b0; merr = 1'b1;
            end else if (bus.s_ret[32]) begin
                mlast = mown; mown = -1;
            end else begin
                mage++;
                if (mage > TO) mexp = 1'b1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_fwd  = '0;
        bus.m1_fwd  = '0;
        bus.s_ret   = '0;
        bus.err_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
    endtask

    function automatic vec_t mkv(input logic [68:0] m0, input logic [68:0] m1, input logic [32:0] sr,
                                 input logic [1:0] g, input logic [32:0] r0, input logic [32:0] r1,
                                 input logic [68:0] sf);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.sr = sr; v.g = g; v.r0 = r0; v.r1 = r1; v.sf = sf;
        return v;
    endfunction

    initial begin
        logic [68:0] f0, f1, z;
        logic [32:0] rz;
        vec_t tbl[10];
        int c0, c1;

        z  = '0;
        rz = '0;
        f0 = {32'h0, 4'h0, 1'b1, 32'h0000_0004};
        f1 = {32'hA5A5_0F0F, 4'b0101, 1'b1, 32'h0001_0008};

        // single master read, then m1 write passthrough and a late ready in IDLE
        tbl[0] = mkv(f0, z, rz, 2'b00, rz, rz, z);
        tbl[1] = mkv(f0, z, rz, 2'b01, rz, rz, f0);
        tbl[2] = mkv(f0, z, rz, 2'b01, rz, rz, f0);
        tbl[3] = mkv(f0, z, {1'b1, 32'h1234_5678}, 2'b01, {1'b1, 32'h1234_5678}, rz, f0);
        tbl[4] = mkv(z, z, rz, 2'b00, rz, rz, z);
        tbl[5] = mkv(z, f1, rz, 2'b00, rz, rz, z);
        tbl[6] = mkv(z, f1, rz, 2'b10, rz, rz, f1);
        tbl[7] = mkv(z, f1, {1'b1, 32'hCAFE_F00D}, 2'b10, rz, {1'b1, 32'hCAFE_F00D}, f1);
        tbl[8] = mkv(z, z, {1'b1, 32'h1111_2222}, 2'b00, rz, rz, z);
        tbl[9] = mkv(z, z, rz, 2'b00, rz, rz, z);

        clear_inputs();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            bus.m0_fwd = tbl[i].m0;
            bus.m1_fwd = tbl[i].m1;
            bus.s_ret  = tbl[i].sr;
            @(negedge clk);
            chk("tbl_grant",  69'(bus.grant),       69'(tbl[i].g));
            chk("tbl_m0_ret", 69'(bus.m0_ret),      69'(tbl[i].r0));
            chk("tbl_m1_ret", 69'(bus.m1_ret),      69'(tbl[i].r1));
            chk("tbl_s_fwd",  bus.s_fwd,            tbl[i].sf);
            chk("tbl_err",    69'(bus.timeout_err), 69'(0));
            advance();
        end

        // contention right after reset: strict alternation starting with m0
        do_reset();
        bus.m0_fwd = {32'h0, 4'h0, 1'b1, 32'h0000_0100};
        bus.m1_fwd = {32'h0, 4'h0, 1'b1, 32'h0000_0200};
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 16; k++) begin
            bus.s_ret = (k % 2 == 1) ? {1'b1, 32'(k)} : 33'h0;
            settle();
            chk("rr_grant", 69'(bus.grant),
                69'((k % 2 == 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10)));
            if (bus.m0_ret[32]) c0++;
            if (bus.m1_ret[32]) c1++;
            advance();
        end
        chk("rr_m0_done", 69'(c0), 69'(4));
        chk("rr_m1_done", 69'(c1), 69'(4));

        // silent slave: forced completion, sticky flag, set beats clear
        do_reset();
        bus.m1_fwd = {32'h0, 4'h0, 1'b1, 32'h0000_0040};
        for (int k = 0; k < 16; k++) begin
            if (k == 13) bus.m1_fwd = '0;
            bus.err_clr = (k == 13 || k == 14);
            settle();
            if (k == 6) begin
                chk("to_m1_ret",   69'(bus.m1_ret),   69'({1'b1, TOD}));
                chk("to_s_valid",  69'(bus.s_fwd[32]), 69'(0));
            end
            if (k >= 7 && k <= 14) chk("to_err_held", 69'(bus.timeout_err), 69'(1));
            if (k == 15)           chk("to_err_clr",  69'(bus.timeout_err), 69'(0));
            advance();
        end
        bus.err_clr = 1'b0;

        // reset while m1 owns a silent slave, then m0 served normally
        do_reset();
        bus.m1_fwd = {32'h0, 4'h0, 1'b1, 32'h0000_0080};
        for (int k = 0; k < 6; k++) begin
            rst = (k == 2);
            if (k == 3) begin
                bus.m1_fwd = '0;
                bus.m0_fwd = {32'h0, 4'h0, 1'b1, 32'h0000_0010};
            end
            bus.s_ret = (k == 4) ? {1'b1, 32'h5555_AAAA} : 33'h0;
            settle();
            if (k == 3) begin
                chk("rst_grant",  69'(bus.grant),       69'(0));
                chk("rst_s_fwd",  bus.s_fwd,            69'(0));
                chk("rst_m1_ret", 69'(bus.m1_ret),      69'(0));
                chk("rst_err",    69'(bus.timeout_err), 69'(0));
            end
            if (k == 4) chk("rst_m0_ret", 69'(bus.m0_ret), 69'({1'b1, 32'h5555_AAAA}));
            advance();
        end
        rst = 1'b0;
        clear_inputs();

        // randomized traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            rst         = ($urandom_range(63) == 0);
            bus.m0_fwd  = {$urandom, 4'($urandom), ($urandom_range(1) == 1), $urandom};
            bus.m1_fwd  = {$urandom, 4'($urandom), ($urandom_range(1) == 1), $urandom};
            bus.s_ret   = {($urandom_range(3) == 0), $urandom};
            bus.err_clr = ($urandom_range(7) == 0);
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
